snn_weight_store: RTL and testbench
===================================

Name: snn_weight_store

Overview:
- Weight memory server sitting directly upstream of the SNN multilayer inference engine.
- Answers its weight read channel (w_req/w_addr -> w_valid/w_data) and its write channel (wb_req/wb_addr/wb_wdata -> wb_ack).
- Also accepts a direct host load port, so packed signed-nibble weights (e.g. W1|W2 at addr 0, W3|W4 at addr 1) can be written from the tile pins before or between inferences.

Parameters:
- ADDR_W, 2, address width; memory depth is 2**ADDR_W words.
- DW, 8, word width (two signed 4-bit weights per word).
- RD_LAT, 1, cycles from accepted w_req to the w_valid pulse; legal range 1..3.
- INIT0, 8'h12, reset content of word 0.
- INIT1, 8'h21, reset content of word 1; all other words reset to 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- w_req  in  1  read request, one-cycle pulse from the consumer
- w_addr  in  ADDR_W  read address, valid with w_req
- w_valid  out  1  read data valid, one-cycle pulse
- w_data  out  DW  read data; 0 whenever w_valid=0
- wb_req  in  1  write request, level; held by the requester until wb_ack
- wb_addr  in  ADDR_W  write address, stable while wb_req=1
- wb_wdata  in  DW  write data, stable while wb_req=1
- wb_ack  out  1  write complete, one-cycle pulse
- ld_en  in  1  host load strobe
- ld_addr  in  ADDR_W  host load address
- ld_data  in  DW  host load data
- busy  out  1  high while not in S_IDLE
- par_err  out  1  sticky parity error flag (see Optional Feature)

Behaviour:
- Reset:
  - Reset is sampled on the clk edge while rst_n=0, synchronous only.
  - FSM goes to S_IDLE; w_valid, w_data, wb_ack, busy and par_err all go to 0.
  - Memory reloads INIT0, INIT1, then zeros in all remaining words.
  - Reset mid-operation abandons any read or write in flight: no w_valid or wb_ack pulse is produced, and a half-done write does not change memory.
- S_IDLE:
  - If w_req=1: latch snapshot = mem[w_addr], load lat_cnt = RD_LAT-1, go to S_RD. Read wins over a simultaneous wb_req.
  - Else if wb_req=1: latch wb_addr and wb_wdata, go to S_WR.
- S_RD:
  - If lat_cnt=0: w_valid=1 and w_data=snapshot this cycle, then return to S_IDLE.
  - Otherwise decrement lat_cnt.
  - Net effect: w_req accepted at edge t gives w_valid high during cycle t+RD_LAT.
  - w_req arriving while busy is ignored (dropped). The consumer only issues a new request after receiving w_valid.
- S_WR:
  - At the next edge, write mem[addr] = data and assert wb_ack for exactly one cycle, then return to S_IDLE.
  - Because wb_req is a level signal, a write that lost arbitration to a read is served after that read completes.
  - If the requester keeps wb_req high in the cycle after the ack, it is treated as a new write.
- Host load port:
  - ld_en writes mem[ld_addr] = ld_data at the edge, in any state, no handshake.
  - ld_en and an S_WR commit to the same address on the same edge: ld_data wins.
  - A read snapshot is taken at acceptance, so a load after acceptance does not alter an in-flight response.
  - A read accepted on the same edge as a load returns the pre-load value.
- Read-after-write:
  - A read accepted in the cycle after wb_ack returns the new value.
- Widths:
  - Data is stored and returned unmodified; no arithmetic.
  - Every address in 0..2**ADDR_W-1 is valid, so there is no out-of-range case.
- FSM encoding: S_IDLE=0, S_RD=1, S_WR=2. Any illegal state returns to S_IDLE on the next edge.

Optional Feature:
- Macro: WSTORE_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit, computed on every write from either the wb or the ld path.
  - On a read, a parity mismatch sets par_err, which stays set until reset.
  - w_data is still returned unchanged.
- When undefined: no parity storage, and par_err is tied to 0.

Test Plan:
- Reset, then read addr0 and addr1 with RD_LAT=1 -> w_valid one cycle after each w_req, with w_data=8'h12 then 8'h21; busy high for exactly 1 cycle per read.
- wb_req write 8'hF3 to addr1 -> wb_ack one pulse 1 cycle after acceptance; a following read of addr1 returns 8'hF3.
- w_req (addr0) and wb_req (addr0, data 8'hAA) asserted in the same cycle -> read returns 8'h12 first, then wb_ack; a subsequent read returns 8'hAA.
- RD_LAT=3: w_req at cycle t -> w_valid at t+3; a second w_req at t+1 is ignored, producing no extra w_valid.
- Same edge: ld_en addr2 8'h55 and S_WR commit to addr2 with 8'h66 -> a later read returns 8'h55. Then rst_n=0 during S_RD -> no w_valid, and all memory words are back to reset content.
- With WSTORE_PARITY_EN defined: force a stored parity bit to be flipped, then read that word -> par_err=1 and stays 1 until reset. Without the macro, par_err stays 0.

Source files
------------

// File: rtl/snn_weight_store.sv
// Weight memory server for the SNN inference engine: a read channel with fixed latency, a
// level-handshake write channel and a host load port. Define WSTORE_PARITY_EN to add per-word parity.
module snn_weight_store #(
    parameter int              ADDR_W = 2,
    parameter int              DW     = 8,
    parameter int              RD_LAT = 1,
    parameter logic [DW-1:0]   INIT0  = 8'h12,
    parameter logic [DW-1:0]   INIT1  = 8'h21
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_req,
    input  logic [ADDR_W-1:0] w_addr,
    output logic              w_valid,
    output logic [DW-1:0]     w_data,
    input  logic              wb_req,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DW-1:0]     wb_wdata,
    output logic              wb_ack,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DW-1:0]     ld_data,
    output logic              busy,
    output logic              par_err
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [1:0]          lat_q, lat_d;
    logic [DW-1:0]       snap_q, snap_d;
    logic [ADDR_W-1:0]   wa_q, wa_d;
    logic [DW-1:0]       wd_q, wd_d;
    logic [DW-1:0]       mem_q [DEPTH];
    logic                rd_done, wr_done;

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        snap_d  = snap_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        rd_done = 1'b0;
        wr_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_req) begin
                    snap_d  = mem_q[w_addr];
                    lat_d   = 2'(RD_LAT - 1);
                    state_d = S_RD;
                end else if (wb_req) begin
                    wa_d    = wb_addr;
                    wd_d    = wb_wdata;
                    state_d = S_WR;
                end
            end
            S_RD: begin
                if (lat_q == 2'd0) begin
                    rd_done = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            S_WR: begin
                wr_done = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            snap_q  <= '0;
            wa_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            snap_q  <= snap_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
        end
    end

    // Host load is ordered after the write commit so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            mem_q[0] <= INIT0;
            mem_q[1] <= INIT1;
        end else begin
            if (wr_done) mem_q[wa_q] <= wd_q;
            if (ld_en)   mem_q[ld_addr] <= ld_data;
        end
    end

    // Gating with rst_n keeps a reset cycle from ever showing a completion pulse.
    assign w_valid = rd_done & rst_n;
    assign wb_ack  = wr_done & rst_n;
    assign w_data  = w_valid ? snap_q : '0;
    assign busy    = (state_q != S_IDLE);

`ifdef WSTORE_PARITY_EN
    logic par_q [DEPTH];
    logic snap_par_q;
    logic par_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) par_q[i] <= 1'b0;
            par_q[0]   <= ^INIT0;
            par_q[1]   <= ^INIT1;
            snap_par_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            if (wr_done) par_q[wa_q] <= ^wd_q;
            if (ld_en)   par_q[ld_addr] <= ^ld_data;
            if (state_q == S_IDLE && w_req) snap_par_q <= par_q[w_addr];
            if (rd_done && ((^snap_q) != snap_par_q)) par_err_q <= 1'b1;
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_snn_weight_store.sv
// Scoreboard bench for snn_weight_store: one RD_LAT=1 instance and one RD_LAT=3 instance.
module tb_snn_weight_store;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        int         due;
    } rd_exp_t;

    rd_exp_t q1[$];
    rd_exp_t q3[$];
    int      ack_q[$];
    rd_exp_t e1, e3;
    int      ea;
    bit      done3 = 1'b0;

    // ---------------- RD_LAT = 1 instance ----------------
    logic       rst_n, w_req, wb_req, ld_en;
    logic [1:0] w_addr, wb_addr, ld_addr;
    logic [7:0] wb_wdata, ld_data;
    logic       w_valid, wb_ack, busy, par_err;
    logic [7:0] w_data;

    snn_weight_store #(.ADDR_W(2), .DW(8), .RD_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .w_req(w_req), .w_addr(w_addr), .w_valid(w_valid), .w_data(w_data),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_ack(wb_ack),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .busy(busy), .par_err(par_err)
    );

    // ---------------- RD_LAT = 3 instance ----------------
    logic       rst3_n, w3_req, ld3_en;
    logic [1:0] w3_addr, ld3_addr;
    logic [7:0] ld3_data;
    logic       wb3_req = 1'b0;
    logic [1:0] wb3_addr = 2'd0;
    logic [7:0] wb3_wdata = 8'd0;
    logic       w3_valid, wb3_ack, busy3, par3_err;
    logic [7:0] w3_data;

    snn_weight_store #(.ADDR_W(2), .DW(8), .RD_LAT(3)) u3 (
        .clk(clk), .rst_n(rst3_n),
        .w_req(w3_req), .w_addr(w3_addr), .w_valid(w3_valid), .w_data(w3_data),
        .wb_req(wb3_req), .wb_addr(wb3_addr), .wb_wdata(wb3_wdata), .wb_ack(wb3_ack),
        .ld_en(ld3_en), .ld_addr(ld3_addr), .ld_data(ld3_data),
        .busy(busy3), .par_err(par3_err)
    );

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (w_valid) begin
            if (q1.size() == 0) chk("rd1_unexpected_valid", 32'd1, 32'd0);
            else begin
                e1 = q1.pop_front();
                chk("rd1_data", w_data, e1.d);
                chk("rd1_cycle", cyc, e1.due);
            end
        end else chk("rd1_data_zero", w_data, 32'd0);
        if (wb_ack) begin
            if (ack_q.size() == 0) chk("wb_unexpected_ack", 32'd1, 32'd0);
            else begin
                ea = ack_q.pop_front();
                chk("wb_ack_cycle", cyc, ea);
            end
        end
    end

    always @(negedge clk) begin
        if (w3_valid) begin
            if (q3.size() == 0) chk("rd3_unexpected_valid", 32'd1, 32'd0);
            else begin
                e3 = q3.pop_front();
                chk("rd3_data", w3_data, e3.d);
                chk("rd3_cycle", cyc, e3.due);
            end
        end
        if (wb3_ack) chk("wb3_unexpected_ack", 32'd1, 32'd0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic rd1(input logic [1:0] a, input logic [7:0] d);
        w_req = 1'b1; w_addr = a;
        q1.push_back('{d, cyc + 1});
        @(posedge clk); #1 w_req = 1'b0;
        @(negedge clk); chk("busy_during_rd", busy, 32'd1);
        @(negedge clk); chk("busy_after_rd", busy, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_ack();
        bit got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = wb_ack;
        end
        if (!got) chk("wb_ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1 wb_req = 1'b0;
    endtask

    task automatic wr1(input logic [1:0] a, input logic [7:0] d);
        wb_req = 1'b1; wb_addr = a; wb_wdata = d;
        ack_q.push_back(cyc + 1);
        wait_ack();
    endtask

    task automatic rd3(input logic [1:0] a, input logic [7:0] d);
        w3_req = 1'b1; w3_addr = a;
        q3.push_back('{d, cyc + 3});
        @(posedge clk); #1 w3_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // ---------------- RD_LAT = 3 sequence ----------------
    initial begin
        rst3_n = 1'b0; w3_req = 1'b0; w3_addr = '0;
        ld3_en = 1'b0; ld3_addr = '0; ld3_data = '0;
        repeat (2) @(posedge clk);
        #1 rst3_n = 1'b1;
        @(posedge clk); #1;
        // first request accepted, the one in the following cycle is dropped
        w3_req = 1'b1; w3_addr = 2'd0;
        q3.push_back('{8'h12, cyc + 3});
        @(posedge clk); #1 w3_addr = 2'd1;
        @(posedge clk); #1 w3_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        // load during an in-flight read does not alter that response
        w3_req = 1'b1; w3_addr = 2'd1;
        q3.push_back('{8'h21, cyc + 3});
        @(posedge clk); #1 w3_req = 1'b0;
        ld3_en = 1'b1; ld3_addr = 2'd1; ld3_data = 8'h77;
        @(posedge clk); #1 ld3_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rd3(2'd1, 8'h77);
        // reset during S_RD abandons the read and reloads memory
        w3_req = 1'b1; w3_addr = 2'd0;
        @(posedge clk); #1 w3_req = 1'b0;
        @(posedge clk); #1 rst3_n = 1'b0;
        @(posedge clk); #1 rst3_n = 1'b1;
        chk("busy3_after_reset", busy3, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rd3(2'd1, 8'h21);
        chk("par3_err_off", par3_err, 32'd0);
        done3 = 1'b1;
    end

    // ---------------- RD_LAT = 1 sequence ----------------
    initial begin
        rst_n = 1'b0; w_req = 1'b0; w_addr = '0;
        wb_req = 1'b0; wb_addr = '0; wb_wdata = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_w_valid", w_valid, 32'd0);
        chk("rst_wb_ack", wb_ack, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_par_err", par_err, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        rd1(2'd0, 8'h12);
        rd1(2'd1, 8'h21);

        wr1(2'd1, 8'hF3);
        rd1(2'd1, 8'hF3);

        // read and write requested together: read first, write served afterwards
        w_req = 1'b1; w_addr = 2'd0;
        wb_req = 1'b1; wb_addr = 2'd0; wb_wdata = 8'hAA;
        q1.push_back('{8'h12, cyc + 1});
        ack_q.push_back(cyc + 3);
        @(posedge clk); #1 w_req = 1'b0;
        wait_ack();
        rd1(2'd0, 8'hAA);

        // read accepted on the same edge as a load returns the pre-load value
        w_req = 1'b1; w_addr = 2'd3;
        ld_en = 1'b1; ld_addr = 2'd3; ld_data = 8'h3C;
        q1.push_back('{8'h00, cyc + 1});
        @(posedge clk); #1 w_req = 1'b0; ld_en = 1'b0;
        @(posedge clk); #1;
        rd1(2'd3, 8'h3C);

        // load and write commit to the same address on the same edge: load wins
        wb_req = 1'b1; wb_addr = 2'd2; wb_wdata = 8'h66;
        ack_q.push_back(cyc + 1);
        @(posedge clk); #1;
        ld_en = 1'b1; ld_addr = 2'd2; ld_data = 8'h55;
        wait_ack();
        ld_en = 1'b0;
        rd1(2'd2, 8'h55);

        // reset while in S_RD: no response, memory back to reset content
        w_req = 1'b1; w_addr = 2'd1;
        @(posedge clk); #1 w_req = 1'b0; rst_n = 1'b0;
        @(negedge clk); chk("busy_before_reset", busy, 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        chk("busy_after_reset", busy, 32'd0);
        rd1(2'd0, 8'h12);
        rd1(2'd1, 8'h21);
        rd1(2'd2, 8'h00);
        rd1(2'd3, 8'h00);

        // reset while in S_WR: no ack and no memory change
        wb_req = 1'b1; wb_addr = 2'd0; wb_wdata = 8'h99;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1; wb_req = 1'b0;
        @(posedge clk); #1;
        rd1(2'd0, 8'h12);

`ifdef WSTORE_PARITY_EN
        force u1.par_q[3] = 1'b1;
        @(posedge clk); #1;
        rd1(2'd3, 8'h00);
        release u1.par_q[3];
        chk("par_err_set", par_err, 32'd1);
        repeat (3) @(posedge clk);
        #1 chk("par_err_sticky", par_err, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        chk("par_err_cleared", par_err, 32'd0);
`else
        chk("par_err_off", par_err, 32'd0);
`endif

        for (int i = 0; i < 2000 && !done3; i++) @(posedge clk);
        chk("u3_sequence_done", 32'(done3), 32'd1);
        repeat (2) @(posedge clk);
        chk("q1_drained", q1.size(), 32'd0);
        chk("q3_drained", q3.size(), 32'd0);
        chk("ack_q_drained", ack_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
